// File: rtl/pwm_sample_feeder.sv
// Scales, saturates and buffers bursty audio samples, then releases one per PWM frame.
// Optional DC blocker on the write path is enabled by defining PWM_FEEDER_DC_BLOCK_EN.
module pwm_sample_feeder #(
  parameter int IN_W      = 16,
  parameter int SHIFT     = 6,
  parameter int DEPTH_LG  = 3,
  parameter int FRAME_LEN = 1024,
  parameter int DC_SHIFT  = 10
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [IN_W-1:0]     sample_in,
  input  logic                sample_valid,
  output logic                sample_ready,
  output logic [11:0]         data_out,
  output logic                frame_tick,
  output logic                underflow,
  output logic                overflow,
  output logic [DEPTH_LG:0]   fifo_level,
  output logic                dbg_state
);

  localparam int DEPTH = 1 << DEPTH_LG;
  localparam int CNT_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;

  localparam logic [CNT_W-1:0]    CNT_LAST = CNT_W'(FRAME_LEN - 1);
  localparam logic [CNT_W-1:0]    CNT_ONE  = CNT_W'(1);
  localparam logic [DEPTH_LG:0]   LVL_FULL = (DEPTH_LG+1)'(DEPTH);
  localparam logic [DEPTH_LG:0]   LVL_HALF = (DEPTH_LG+1)'(DEPTH / 2);
  localparam logic [DEPTH_LG:0]   LVL_ONE  = (DEPTH_LG+1)'(1);
  localparam logic [DEPTH_LG-1:0] PTR_ONE  = DEPTH_LG'(1);

  localparam logic signed [IN_W-1:0] IN_HI = IN_W'(511);
  localparam logic signed [IN_W-1:0] IN_LO = IN_W'(-512);

  // Handshake: a sample is taken on any cycle where sample_valid && sample_ready;
  // sample_ready depends only on the registered FIFO level, never on sample_valid.

  typedef enum logic {
    ST_PRIME = 1'b0,
    ST_RUN   = 1'b1
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DEPTH_LG-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LG-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LG:0]   level_q, level_d;
  logic [11:0]         data_q, data_d;
  logic                tick_q, tick_d;
  logic                uf_q, uf_d;
  logic                of_q, of_d;
  logic [11:0]         mem_q [DEPTH];

  logic                      at_pop;
  logic                      full;
  logic                      empty;
  logic                      push;
  logic                      pop;
  logic signed [IN_W-1:0]    shifted;
  logic signed [11:0]        s_sat;
  logic [11:0]               wr_data;

  function automatic logic [11:0] sat12(input logic signed [31:0] v);
    if (v > 32'sd511) begin
      sat12 = 12'h1FF;
    end else if (v < -32'sd512) begin
      sat12 = 12'hE00;
    end else begin
      sat12 = v[11:0];
    end
  endfunction

  assign shifted = $signed(sample_in) >>> SHIFT;

  always_comb begin
    s_sat = shifted[11:0];
    if (shifted > IN_HI) begin
      s_sat = 12'sh1FF;
    end else if (shifted < IN_LO) begin
      s_sat = -12'sh200;
    end
  end

`ifdef PWM_FEEDER_DC_BLOCK_EN
  localparam int ACC_W = 12 + DC_SHIFT;

  // dc_acc_q holds the DC estimate scaled by 2**DC_SHIFT.
  logic signed [ACC_W-1:0] dc_acc_q, dc_acc_d;
  logic signed [ACC_W-1:0] dc_int;
  logic signed [ACC_W-1:0] dc_diff;

  assign dc_int  = dc_acc_q >>> DC_SHIFT;
  assign dc_diff = ACC_W'(s_sat) - dc_int;

  always_comb begin
    dc_acc_d = dc_acc_q;
    if (push) begin
      dc_acc_d = dc_acc_q + dc_diff;
    end
    wr_data = sat12(32'(dc_diff));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dc_acc_q <= '0;
    end else begin
      dc_acc_q <= dc_acc_d;
    end
  end
`else
  logic unused_dc_shift;
  assign unused_dc_shift = (DC_SHIFT != 0);
  assign wr_data = sat12(32'(s_sat));
`endif

  assign at_pop = (cnt_q == CNT_LAST);
  assign full   = (level_q == LVL_FULL);
  assign empty  = (level_q == '0);
  assign push   = sample_valid && !full;
  assign pop    = (state_q == ST_RUN) && at_pop && !empty;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q + CNT_ONE;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    data_d   = data_q;
    tick_d   = at_pop;
    uf_d     = uf_q;
    of_d     = of_q | (sample_valid & full);

    if (at_pop) begin
      cnt_d = '0;
    end

    case (state_q)
      ST_PRIME: begin
        if (level_q >= LVL_HALF) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        // Running dry at a pop point keeps the last sample and re-primes.
        if (at_pop && empty) begin
          uf_d    = 1'b1;
          state_d = ST_PRIME;
        end
      end
      default: state_d = ST_PRIME;
    endcase

    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
      data_d   = mem_q[rd_ptr_q];
    end

    case ({push, pop})
      2'b10:   level_d = level_q + LVL_ONE;
      2'b01:   level_d = level_q - LVL_ONE;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_PRIME;
      cnt_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      data_q   <= '0;
      tick_q   <= 1'b0;
      uf_q     <= 1'b0;
      of_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      data_q   <= data_d;
      tick_q   <= tick_d;
      uf_q     <= uf_d;
      of_q     <= of_d;
    end
  end

  // Storage needs no reset: the level and pointers define which entries are live.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  assign sample_ready = !full;
  assign data_out     = data_q;
  assign frame_tick   = tick_q;
  assign underflow    = uf_q;
  assign overflow     = of_q;
  assign fifo_level   = level_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_pwm_sample_feeder.sv
// Self-checking bench for pwm_sample_feeder: queue-based reference model plus directed
// and randomized scenarios; each scenario task makes its own comparisons.
module tb_pwm_sample_feeder;

  localparam int FRAME_LEN = 1024;
  localparam int DC_SHIFT  = 10;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] sample_in = '0;
  logic        sample_valid = 1'b0;
  logic        sample_ready;
  logic [11:0] data_out;
  logic        frame_tick;
  logic        underflow;
  logic        overflow;
  logic [3:0]  fifo_level;
  logic        dbg_state;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  pwm_sample_feeder dut (
    .clk          (clk),
    .rst          (rst),
    .sample_in    (sample_in),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .data_out     (data_out),
    .frame_tick   (frame_tick),
    .underflow    (underflow),
    .overflow     (overflow),
    .fifo_level   (fifo_level),
    .dbg_state    (dbg_state)
  );

  // Reference model: expected FIFO contents as a queue, frame position from edge count.
  logic [11:0] exp_q[$];
  bit          m_run;
  int          m_cyc;
  int          m_lvl;
  bit          m_pop_pt;
  logic [11:0] m_data;
  bit          m_tick;
  bit          m_uf;
  bit          m_of;
  longint      m_dc;

  function automatic int sat(input longint v);
    if (v > 511) return 511;
    if (v < -512) return -512;
    return int'(v);
  endfunction

  function automatic logic [11:0] scale(input logic [15:0] x);
    int xi;
    xi = int'($signed(x));
    return 12'(sat(xi >>> 6));
  endfunction

  function automatic logic [11:0] model_accept(input logic [15:0] x);
    int s;
`ifdef PWM_FEEDER_DC_BLOCK_EN
    longint y;
`endif
    s = sat(int'($signed(x)) >>> 6);
`ifdef PWM_FEEDER_DC_BLOCK_EN
    y    = s - (m_dc >>> DC_SHIFT);
    m_dc = m_dc + y;
    s    = sat(y);
`endif
    return 12'(s);
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      exp_q.delete();
      m_run = 1'b0; m_cyc = 0; m_data = '0; m_tick = 1'b0;
      m_uf = 1'b0; m_of = 1'b0; m_dc = 0;
    end else begin
      m_lvl    = exp_q.size();
      m_cyc    = m_cyc + 1;
      m_pop_pt = (m_cyc % FRAME_LEN) == 0;
      m_tick   = m_pop_pt;
      if (m_run) begin
        if (m_pop_pt && m_lvl > 0) m_data = exp_q.pop_front();
        else if (m_pop_pt) begin m_uf = 1'b1; m_run = 1'b0; end
      end else if (m_lvl >= 4) begin
        m_run = 1'b1;
      end
      if (sample_valid) begin
        if (m_lvl >= 8) m_of = 1'b1;
        else exp_q.push_back(model_accept(sample_in));
      end
    end
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic push(input logic [15:0] v);
    sample_in    = v;
    sample_valid = 1'b1;
    step();
    sample_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    sample_valid = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  // Steps until the DUT pulses frame_tick, giving up after two frames.
  task automatic wait_tick(output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (frame_tick !== 1'b1 && n < 2 * FRAME_LEN + 50);
  endtask

  task automatic goto_pre_pop();
    for (int k = 0; k < 2 * FRAME_LEN && (m_cyc % FRAME_LEN) != FRAME_LEN - 1; k++) step();
  endtask

  task automatic test_reset();
    int n;
    do_reset();
    n_checks++;
    if ({data_out, frame_tick, underflow, overflow, fifo_level, sample_ready, dbg_state} !==
        {12'd0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0})
      $display("FAIL reset_state: got d=%0h t=%0b u=%0b o=%0b l=%0d r=%0b s=%0b expected d=0 t=0 u=0 o=0 l=0 r=1 s=0",
               data_out, frame_tick, underflow, overflow, fifo_level, sample_ready, dbg_state);
    else n_pass++;
    wait_tick(n);
    n_checks++;
    if (n !== FRAME_LEN || frame_tick !== 1'b1)
      $display("FAIL first_tick: got %0d clocks expected %0d", n, FRAME_LEN);
    else n_pass++;
    n_checks++;
    if (data_out !== 12'd0 || dbg_state !== 1'b0)
      $display("FAIL prime_hold: got d=%0h s=%0b expected d=0 s=0", data_out, dbg_state);
    else n_pass++;
  endtask

  task automatic test_stream();
    logic [15:0] vin [4];
    logic [11:0] vexp [4];
    int n;
    vin  = '{16'h0400, 16'h0800, 16'hFC00, 16'h7FFF};
    vexp = '{12'd16, 12'd32, 12'hFF0, 12'h1FF};
    do_reset();
    for (int i = 0; i < 4; i++) push(vin[i]);
    step();
    n_checks++;
    if (dbg_state !== 1'b1 || fifo_level !== 4'd4)
      $display("FAIL enter_run: got s=%0b l=%0d expected s=1 l=4", dbg_state, fifo_level);
    else n_pass++;
    for (int i = 0; i < 4; i++) begin
      wait_tick(n);
      n_checks++;
      if (data_out !== vexp[i] || (i > 0 && n !== FRAME_LEN))
        $display("FAIL stream_pop%0d: got %0h after %0d clocks expected %0h after %0d",
                 i, data_out, n, vexp[i], FRAME_LEN);
      else n_pass++;
    end
    wait_tick(n);
    n_checks++;
    if (underflow !== 1'b1 || data_out !== 12'h1FF || dbg_state !== 1'b0 || fifo_level !== 4'd0)
      $display("FAIL underflow_hold: got u=%0b d=%0h s=%0b l=%0d expected u=1 d=1ff s=0 l=0",
               underflow, data_out, dbg_state, fifo_level);
    else n_pass++;
    for (int i = 0; i < 4; i++) push(16'($urandom));
    for (int i = 0; i < 4; i++) begin
      wait_tick(n);
      n_checks++;
      if (data_out !== m_data || frame_tick !== m_tick)
        $display("FAIL refill_pop%0d: got %0h expected %0h", i, data_out, m_data);
      else n_pass++;
    end
    n_checks++;
    if (underflow !== 1'b1 || overflow !== 1'b0)
      $display("FAIL sticky_flags: got u=%0b o=%0b expected u=1 o=0", underflow, overflow);
    else n_pass++;
  endtask

  task automatic test_saturation();
    logic [15:0] vin [4];
    logic [11:0] vexp [4];
    int n;
    vin  = '{16'h8000, 16'h7FFF, 16'h7FC0, 16'h8040};
    vexp = '{12'hE00, 12'h1FF, 12'h1FF, 12'hE01};
    do_reset();
    for (int i = 0; i < 4; i++) push(vin[i]);
    for (int i = 0; i < 4; i++) begin
      wait_tick(n);
      n_checks++;
      if (data_out !== vexp[i])
        $display("FAIL saturate%0d: got %0h expected %0h", i, data_out, vexp[i]);
      else n_pass++;
    end
  endtask

  task automatic test_overflow();
    logic [15:0] r [9];
    logic [11:0] e [9];
    int n;
    do_reset();
    for (int i = 0; i < 9; i++) begin
      r[i] = 16'($urandom);
      e[i] = scale(r[i]);
      push(r[i]);
      if (i == 7) begin
        n_checks++;
        if (sample_ready !== 1'b0 || fifo_level !== 4'd8 || overflow !== 1'b0)
          $display("FAIL full_after_8: got r=%0b l=%0d o=%0b expected r=0 l=8 o=0",
                   sample_ready, fifo_level, overflow);
        else n_pass++;
      end
    end
    n_checks++;
    if (overflow !== 1'b1 || fifo_level !== 4'd8)
      $display("FAIL overflow_9th: got o=%0b l=%0d expected o=1 l=8", overflow, fifo_level);
    else n_pass++;
    goto_pre_pop();
    push(16'h1234);
    n_checks++;
    if (fifo_level !== 4'd7 || frame_tick !== 1'b1 || data_out !== e[0])
      $display("FAIL full_push_pop: got l=%0d t=%0b d=%0h expected l=7 t=1 d=%0h",
               fifo_level, frame_tick, data_out, e[0]);
    else n_pass++;
    for (int i = 1; i < 8; i++) begin
      wait_tick(n);
      n_checks++;
      if (data_out !== e[i])
        $display("FAIL overflow_pop%0d: got %0h expected %0h", i, data_out, e[i]);
      else n_pass++;
    end
    wait_tick(n);
    n_checks++;
    if (underflow !== 1'b1 || data_out !== e[7])
      $display("FAIL ninth_absent: got u=%0b d=%0h expected u=1 d=%0h", underflow, data_out, e[7]);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [15:0] x;
    logic [11:0] e [6];
    int n;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      x = 16'($urandom);
      e[i] = scale(x);
      push(x);
    end
    goto_pre_pop();
    x = 16'($urandom);
    e[5] = scale(x);
    push(x);
    n_checks++;
    if (fifo_level !== 4'd5 || data_out !== e[0])
      $display("FAIL push_pop_same: got l=%0d d=%0h expected l=5 d=%0h", fifo_level, data_out, e[0]);
    else n_pass++;
    for (int i = 1; i < 6; i++) begin
      wait_tick(n);
      n_checks++;
      if (data_out !== e[i] || data_out !== m_data)
        $display("FAIL b2b_pop%0d: got %0h expected %0h", i, data_out, e[i]);
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid();
    int n;
    do_reset();
    for (int i = 0; i < 9; i++) push(16'($urandom));
    for (int i = 0; i < 3; i++) wait_tick(n);
    n_checks++;
    if (fifo_level !== 4'd5 || overflow !== 1'b1 || dbg_state !== 1'b1)
      $display("FAIL pre_reset: got l=%0d o=%0b s=%0b expected l=5 o=1 s=1", fifo_level, overflow, dbg_state);
    else n_pass++;
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_checks++;
    if ({fifo_level, data_out, underflow, overflow, frame_tick, dbg_state} !== {4'd0, 12'd0, 4'b0000})
      $display("FAIL mid_reset: got l=%0d d=%0h u=%0b o=%0b t=%0b s=%0b expected all 0",
               fifo_level, data_out, underflow, overflow, frame_tick, dbg_state);
    else n_pass++;
    wait_tick(n);
    n_checks++;
    if (n !== FRAME_LEN || data_out !== 12'd0)
      $display("FAIL tick_after_reset: got %0d clocks d=%0h expected %0d d=0", n, data_out, FRAME_LEN);
    else n_pass++;
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 12000; c++) begin
      sample_in    = 16'($urandom);
      sample_valid = (c < 6000) ? ($urandom_range(0, 1023) < 3) : ($urandom_range(0, 4095) < 1);
      step();
      n_checks++;
      if (fifo_level !== 4'(exp_q.size()) || sample_ready !== (exp_q.size() < 8) || frame_tick !== m_tick)
        $display("FAIL rand_cycle%0d: got l=%0d r=%0b t=%0b expected l=%0d r=%0b t=%0b", c,
                 fifo_level, sample_ready, frame_tick, exp_q.size(), exp_q.size() < 8, m_tick);
      else n_pass++;
      if (m_tick) begin
        n_checks++;
        if (data_out !== m_data)
          $display("FAIL rand_data%0d: got %0h expected %0h", c, data_out, m_data);
        else n_pass++;
      end
    end
    sample_valid = 1'b0;
    n_checks++;
    if (underflow !== m_uf || overflow !== m_of || dbg_state !== m_run)
      $display("FAIL rand_flags: got u=%0b o=%0b s=%0b expected u=%0b o=%0b s=%0b",
               underflow, overflow, dbg_state, m_uf, m_of, m_run);
    else n_pass++;
  endtask

  task automatic test_dc_steady();
    int n;
    do_reset();
    for (int i = 0; i < 4; i++) push(16'h2000);
    for (int f = 0; f < 6; f++) begin
      wait_tick(n);
      n_checks++;
      if (data_out !== m_data)
        $display("FAIL dc_model%0d: got %0h expected %0h", f, data_out, m_data);
      else n_pass++;
`ifndef PWM_FEEDER_DC_BLOCK_EN
      n_checks++;
      if (data_out !== 12'd128)
        $display("FAIL dc_steady%0d: got %0d expected 128", f, data_out);
      else n_pass++;
`endif
      push(16'h2000);
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_saturation();
    test_overflow();
    test_back_to_back();
    test_reset_mid();
    test_random();
    test_dc_steady();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
